// File: rtl/mc_pkg.sv
// Shared types and constants for the Monte Carlo statistics accumulator.
package mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int MOVE_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;

  localparam logic [3:0] RD_MAX_LO   = 4'd0;
  localparam logic [3:0] RD_MAX_HI   = 4'd1;
  localparam logic [3:0] RD_TOT_B0   = 4'd2;
  localparam logic [3:0] RD_TOT_B1   = 4'd3;
  localparam logic [3:0] RD_TOT_B2   = 4'd4;
  localparam logic [3:0] RD_TOT_B3   = 4'd5;
  localparam logic [3:0] RD_TRIAL_B0 = 4'd6;
  localparam logic [3:0] RD_TRIAL_B1 = 4'd7;
  localparam logic [3:0] RD_TRIAL_B2 = 4'd8;
  localparam logic [3:0] RD_TRIAL_B3 = 4'd9;
  localparam logic [7:0] RD_DEFAULT  = 8'hFF;

endpackage

// File: rtl/mc_stat_accumulator_sat_add.sv
// Saturating adder: the sum clamps to all-ones when the carry-out is set.
module sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[W];
    sum  = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/mc_stat_accumulator.sv
// Per-direction trial statistics (max, total moves, trial count) with a
// snapshot shadow so multi-byte bus reads stay coherent.
module mc_stat_accumulator
  import mc_pkg::*;
#(
  parameter int MOVE_W      = MOVE_W_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int TRIAL_LIMIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              trial_valid,
  input  logic [MOVE_W-1:0] trial_moves,
  output logic              trial_ready,
  input  logic              snap_req,
  input  logic [3:0]        rd_sel,
  output logic [7:0]        rd_data,
  output logic              running,
  output logic              halted
);

  state_t state, state_nxt;

  logic [MOVE_W-1:0] max_q, max_nxt, sh_max;
  logic [ACC_W-1:0]  total_q, total_nxt, sh_total;
  logic [ACC_W-1:0]  trials_q, trials_nxt, sh_trials;
  logic [ACC_W-1:0]  total_sum, trials_sum;
  logic              total_ovf, trials_ovf;
  logic              accept, limit_hit, sat_hit;
  logic [15:0]       sh_max16;
  logic [31:0]       sh_total32, sh_trials32;
  logic [7:0]        rd_byte;

  sat_add #(.W(ACC_W)) u_total_add (
    .a   (total_q),
    .b   (ACC_W'(trial_moves)),
    .sum (total_sum),
    .ovf (total_ovf)
  );

  sat_add #(.W(ACC_W)) u_trials_add (
    .a   (trials_q),
    .b   (ACC_W'(1)),
    .sum (trials_sum),
    .ovf (trials_ovf)
  );

  always_comb begin
    trial_ready = (state == ST_RUN) && !clear && !start;
    accept      = trial_valid && trial_ready;
    limit_hit   = (TRIAL_LIMIT != 0) && (trials_sum == ACC_W'(TRIAL_LIMIT));
    // Reaching all-ones counts as saturated: the counter can no longer grow.
    sat_hit     = total_ovf || trials_ovf || (&total_sum) || (&trials_sum);

    state_nxt  = state;
    max_nxt    = max_q;
    total_nxt  = total_q;
    trials_nxt = trials_q;

    if (clear) begin
      state_nxt  = ST_IDLE;
      max_nxt    = '0;
      total_nxt  = '0;
      trials_nxt = '0;
    end else if (start) begin
      state_nxt  = ST_RUN;
      max_nxt    = '0;
      total_nxt  = '0;
      trials_nxt = '0;
    end else if (accept) begin
      max_nxt    = (trial_moves > max_q) ? trial_moves : max_q;
      total_nxt  = total_sum;
      trials_nxt = trials_sum;
      if (limit_hit || sat_hit) state_nxt = ST_HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      running  <= 1'b0;
      halted   <= 1'b0;
      max_q    <= '0;
      total_q  <= '0;
      trials_q <= '0;
    end else begin
      state    <= state_nxt;
      running  <= (state_nxt == ST_RUN);
      halted   <= (state_nxt == ST_HALT);
      max_q    <= max_nxt;
      total_q  <= total_nxt;
      trials_q <= trials_nxt;
    end
  end

  // Shadow takes the post-update values so a same-cycle accept is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_max    <= '0;
      sh_total  <= '0;
      sh_trials <= '0;
    end else if (snap_req) begin
      sh_max    <= max_nxt;
      sh_total  <= total_nxt;
      sh_trials <= trials_nxt;
    end
  end

  always_comb begin
    sh_max16    = 16'(sh_max);
    sh_total32  = 32'(sh_total);
    sh_trials32 = 32'(sh_trials);
    rd_byte     = RD_DEFAULT;
    case (rd_sel)
      RD_MAX_LO:   rd_byte = sh_max16[7:0];
      RD_MAX_HI:   rd_byte = sh_max16[15:8];
      RD_TOT_B0:   rd_byte = sh_total32[7:0];
      RD_TOT_B1:   rd_byte = sh_total32[15:8];
      RD_TOT_B2:   rd_byte = sh_total32[23:16];
      RD_TOT_B3:   rd_byte = sh_total32[31:24];
      RD_TRIAL_B0: rd_byte = sh_trials32[7:0];
      RD_TRIAL_B1: rd_byte = sh_trials32[15:8];
      RD_TRIAL_B2: rd_byte = sh_trials32[23:16];
      RD_TRIAL_B3: rd_byte = sh_trials32[31:24];
      default:     rd_byte = RD_DEFAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= rd_byte;
  end

endmodule

// File: tb/tb_mc_stat_accumulator.sv
// Bench: two accumulators (32-bit unlimited, 16-bit with a 3-trial limit)
// driven in lockstep and compared against an arithmetic reference model.
module tb_mc_stat_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clear, trial_valid, snap_req;
  logic [15:0] trial_moves;
  logic [3:0]  rd_sel;
  logic        rd_req, rd_fire;

  logic       ready_a, run_a, halt_a, ready_b, run_b, halt_b;
  logic [7:0] rd_a, rd_b;

  always #5 clk = ~clk;

  mc_stat_accumulator #(.MOVE_W(16), .ACC_W(32), .TRIAL_LIMIT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .trial_valid(trial_valid), .trial_moves(trial_moves), .trial_ready(ready_a),
    .snap_req(snap_req), .rd_sel(rd_sel), .rd_data(rd_a),
    .running(run_a), .halted(halt_a)
  );

  mc_stat_accumulator #(.MOVE_W(16), .ACC_W(16), .TRIAL_LIMIT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .trial_valid(trial_valid), .trial_moves(trial_moves), .trial_ready(ready_b),
    .snap_req(snap_req), .rd_sel(rd_sel), .rd_data(rd_b),
    .running(run_b), .halted(halt_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: 0 = idle, 1 = run, 2 = halt.
  int     m_st[2];
  longint m_max[2], m_tot[2], m_trl[2];
  longint s_max[2], s_tot[2], s_trl[2];
  longint acc_max[2] = '{64'hFFFF_FFFF, 64'hFFFF};
  longint limit[2]   = '{0, 3};

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int sel);
    longint v;
    if (sel <= 1)      v = s_max[i] >> (8 * sel);
    else if (sel <= 5) v = s_tot[i] >> (8 * (sel - 2));
    else if (sel <= 9) v = s_trl[i] >> (8 * (sel - 6));
    else               v = 255;
    return 8'(v & 255);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_max[i] = 0; m_tot[i] = 0; m_trl[i] = 0;
      s_max[i] = 0; s_tot[i] = 0; s_trl[i] = 0;
    end
  endtask

  task automatic check_state();
    chk("running_a", run_a, m_st[0] == 1);
    chk("halted_a", halt_a, m_st[0] == 2);
    chk("running_b", run_b, m_st[1] == 1);
    chk("halted_b", halt_b, m_st[1] == 2);
  endtask

  // One clock cycle: drive inputs, check trial_ready, advance the model.
  task automatic step(input bit st, input bit cl, input bit v, input logic [15:0] mv,
                      input bit sn, input bit rq, input int sel);
    bit rdy;
    start = st; clear = cl; trial_valid = v; trial_moves = mv;
    snap_req = sn; rd_req = rq; rd_sel = 4'(sel);
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy = (m_st[i] == 1) && !cl && !st;
      if (i == 0) chk("trial_ready_a", ready_a, rdy);
      else        chk("trial_ready_b", ready_b, rdy);
      if (rq) begin
        if (i == 0) q_a.push_back(exp_byte(0, sel));
        else        q_b.push_back(exp_byte(1, sel));
      end
      if (cl) begin
        m_st[i] = 0; m_max[i] = 0; m_tot[i] = 0; m_trl[i] = 0;
      end else if (st) begin
        m_st[i] = 1; m_max[i] = 0; m_tot[i] = 0; m_trl[i] = 0;
      end else if (v && rdy) begin
        if (longint'(mv) > m_max[i]) m_max[i] = longint'(mv);
        m_tot[i] = m_tot[i] + longint'(mv);
        if (m_tot[i] > acc_max[i]) m_tot[i] = acc_max[i];
        m_trl[i] = m_trl[i] + 1;
        if (m_trl[i] > acc_max[i]) m_trl[i] = acc_max[i];
        if ((limit[i] != 0 && m_trl[i] == limit[i]) ||
            m_tot[i] == acc_max[i] || m_trl[i] == acc_max[i])
          m_st[i] = 2;
      end
      if (sn) begin
        s_max[i] = m_max[i]; s_tot[i] = m_tot[i]; s_trl[i] = m_trl[i];
      end
    end
    @(posedge clk);
    #1;
    start = 0; clear = 0; trial_valid = 0; snap_req = 0; rd_req = 0;
    check_state();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 16'd0, 0, 0, 0);
  endtask

  task automatic read_step(input int sel);
    step(0, 0, 0, 16'd0, 0, 1, sel);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) rd_fire <= 1'b0;
    else     rd_fire <= rd_req;
  end

  always @(negedge clk) begin
    if (rd_fire) begin
      if (q_a.size() == 0) chk("rd_queue_a_underflow", 1, 0);
      else chk("rd_data_a", rd_a, q_a.pop_front());
      if (q_b.size() == 0) chk("rd_queue_b_underflow", 1, 0);
      else chk("rd_data_b", rd_b, q_b.pop_front());
    end
  end

  initial begin
    rst = 1; start = 0; clear = 0; trial_valid = 0; trial_moves = 0;
    snap_req = 0; rd_sel = 0; rd_req = 0;
    model_reset();
    #1;
    chk("reset_rd_data_a", rd_a, 8'h00);
    chk("reset_ready_a", ready_a, 0);
    chk("reset_ready_b", ready_b, 0);
    check_state();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Trial in IDLE is refused.
    step(0, 0, 1, 16'd9, 0, 0, 0);

    // Three trials then snapshot and full byte-map read.
    step(1, 0, 0, 16'd0, 0, 0, 0);
    step(0, 0, 1, 16'd5, 0, 0, 0);
    step(0, 0, 1, 16'd12, 0, 0, 0);
    step(0, 0, 1, 16'd7, 0, 0, 0);
    step(0, 0, 0, 16'd0, 1, 0, 0);
    for (int k = 0; k < 16; k++) read_step(k);

    // Back-to-back valid; limited instance halts after its third accept.
    step(1, 0, 0, 16'd0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 16'(100 + k), 0, 0, 0);
    step(0, 0, 0, 16'd0, 1, 0, 0);
    for (int k = 0; k < 10; k++) read_step(k);

    // Snapshot in the same cycle as an accept sees the new max.
    step(1, 0, 0, 16'd0, 0, 0, 0);
    step(0, 0, 1, 16'd3, 0, 0, 0);
    step(0, 0, 1, 16'd9, 1, 0, 0);
    read_step(0);
    read_step(6);

    // Clear beats a same-cycle trial; shadow survives, live counters zero.
    step(0, 0, 1, 16'd50, 0, 0, 0);
    step(0, 1, 1, 16'd200, 0, 0, 0);
    read_step(0);
    read_step(2);
    step(0, 0, 0, 16'd0, 1, 0, 0);
    for (int k = 0; k < 10; k++) read_step(k);

    // Saturation of the 16-bit total: 60000 + 10000 clamps to FFFF and halts.
    step(1, 0, 0, 16'd0, 0, 0, 0);
    step(0, 0, 1, 16'd60000, 0, 0, 0);
    step(0, 0, 1, 16'd10000, 0, 0, 0);
    step(0, 0, 1, 16'd1, 1, 0, 0);
    for (int k = 0; k < 10; k++) read_step(k);

    // Restart from HALT, then randomized traffic.
    for (int n = 0; n < 80; n++) begin
      bit st, cl, v, sn, rq;
      logic [15:0] mv;
      cl = ($urandom_range(0, 24) == 0);
      st = (m_st[1] != 1) && ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                       : 16'($urandom_range(0, 300));
      sn = ($urandom_range(0, 3) == 0);
      rq = ($urandom_range(0, 1) == 0);
      step(st, cl, v, mv, sn, rq, int'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-run while rd_sel selects a nonzero byte.
    step(1, 0, 0, 16'd0, 0, 0, 0);
    step(0, 0, 1, 16'd40, 1, 0, 0);
    read_step(2);
    step(0, 0, 0, 16'd0, 0, 0, 2);
    #2 rst = 1;
    #1;
    model_reset();
    chk("async_rst_rd_data_a", rd_a, 8'h00);
    chk("async_rst_rd_data_b", rd_b, 8'h00);
    chk("async_rst_ready_a", ready_a, 0);
    check_state();
    @(posedge clk);
    #1 rst = 0;
    idle_step();
    step(1, 0, 0, 16'd0, 0, 0, 0);
    step(0, 0, 0, 16'd0, 1, 0, 0);
    for (int k = 0; k < 10; k++) read_step(k);

    idle_step();
    @(negedge clk);
    chk("rd_queue_a_drained", q_a.size(), 0);
    chk("rd_queue_b_drained", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
